edge_scan_ctrl: RTL and testbench
=================================

EDGE_SCAN_CTRL -- requirements
Module: edge_scan_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 160, image width in pixels (legal range 3..1023).
REQ-002 SHALL have parameter IMG_H, default 120, image height in pixels (legal range 3..1023).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL have ports start (in, 1) and abort (in, 1), synchronous pulses.
REQ-006 SHALL have port threshold_in, input, 8, the edge threshold, latched at start.
REQ-007 SHALL have window-source ports: win_req (out, 1), win_x (out, 10), win_y (out, 10), win_ack (in, 1) and win_grid (in, 72), where the grid is valid in the cycle win_ack is high.
REQ-008 SHALL have detector ports: det_grid (out, 72), det_thresh (out, 8) and det_edge (in, 1), where the detector registers its result one cycle after grid and threshold are presented.
REQ-009 SHALL have result ports: out_valid (out, 1), out_ready (in, 1), out_edge (out, 1), out_x (out, 10) and out_y (out, 10).
REQ-010 SHALL have status ports: busy (out, 1), done (out, 1, one-cycle pulse) and edge_count (out, 16).

Function
REQ-011 SHALL implement the FSM states IDLE, FETCH, EVAL, CAPT, WRITE and DONE.
REQ-012 In IDLE, start=1 SHALL latch threshold_in into thr_q, clear x and y to 0, and go to FETCH; start SHALL be ignored in every other state.
REQ-013 In FETCH, a border pixel (x=0, x=IMG_W-1, y=0 or y=IMG_H-1) SHALL skip the fetch and go to WRITE with result 0.
REQ-014 In FETCH, an interior pixel SHALL assert win_req=1 with win_x=x and win_y=y, and hold them stable until win_ack.
REQ-015 On win_ack, the block SHALL latch win_grid into grid_q and go to EVAL; win_req SHALL drop in the following cycle.
REQ-016 det_grid SHALL equal grid_q and det_thresh SHALL equal thr_q at all times.
REQ-017 EVAL SHALL last exactly 1 cycle and then go to CAPT.
REQ-018 CAPT SHALL sample det_edge into res_q and go to WRITE, giving a fixed latency of 2 cycles from win_ack to WRITE.
REQ-019 In WRITE, out_valid SHALL be 1, with out_edge=res_q, out_x=x and out_y=y held stable until out_ready.
REQ-020 out_valid SHALL NOT drop without a handshake except on abort or reset.
REQ-021 A WRITE handshake SHALL advance the scan raster-order: x+1, wrapping to 0 with y+1 at x=IMG_W-1.
REQ-022 A handshake on the last pixel (x=IMG_W-1, y=IMG_H-1) SHALL go to DONE; any other handshake SHALL go to FETCH.
REQ-023 DONE SHALL assert done=1 for 1 cycle and then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 abort=1 in any non-IDLE state SHALL go to IDLE in the next cycle, dropping win_req and out_valid with no done pulse; abort and start together in IDLE SHALL let start win.
REQ-026 win_ack outside FETCH and out_ready outside WRITE SHALL be ignored.

Reset
REQ-027 rst=1 SHALL force asynchronously: state=IDLE, x=y=0, thr_q=0, grid_q=0, res_q=0, and win_req, out_valid, done, busy and edge_count all 0.
REQ-028 Reset asserted mid-scan SHALL discard the scan; after release the block SHALL wait for start.

Configuration
REQ-029 With EDGE_COUNT_EN defined, edge_count SHALL clear on accepted start and increment (saturating at 0xFFFF) on each WRITE handshake with out_edge=1.
REQ-030 With EDGE_COUNT_EN defined, edge_count SHALL hold its value after DONE or abort.
REQ-031 Without EDGE_COUNT_EN, edge_count SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-032 Case: IMG_W=4, IMG_H=3, start, ack always 1, out_ready always 1, det_edge=1 -> 12 results in raster order; edges only at (1,1) and (2,1); done pulses once; edge_count=2 (with EDGE_COUNT_EN).
REQ-033 Case: win_ack delayed 5 cycles at (1,1) -> win_req and win_x=1/win_y=1 held stable for 5 cycles; out_valid rises exactly 2 cycles after win_ack.
REQ-034 Case: out_ready held low 4 cycles at (0,0) -> out_valid=1 with out_x=0, out_y=0 unchanged; no win_req issued meanwhile.
REQ-035 Case: abort asserted during EVAL of (2,1) -> IDLE next cycle; out_valid never rises for (2,1); done stays 0.
REQ-036 Case: rst pulsed mid-FETCH with win_req=1 -> win_req, busy and out_valid go to 0 immediately; a later start rescans from (0,0).
REQ-037 Case: threshold_in changed from 0x20 to 0x80 mid-scan -> det_thresh stays 0x20 until the next accepted start.

Source files
------------

// File: rtl/edge_scan_ctrl.sv
// Raster-scan controller: walks an IMG_W x IMG_H image, fetches 3x3 windows for
// interior pixels and reports the result of an external edge detector for each pixel.
// Optional build macro EDGE_COUNT_EN adds a saturating counter of reported edges.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | border pixel: skip to WRITE; interior pixel: win_req until win_ack
// EVAL  | grid_q presented to the detector
// CAPT  | detector result sampled into res_q
// WRITE | result offered on out_*, waiting for out_ready
// DONE  | one-cycle done pulse after the last pixel
module edge_scan_ctrl #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  threshold_in,
  output logic        win_req,
  output logic [9:0]  win_x,
  output logic [9:0]  win_y,
  input  logic        win_ack,
  input  logic [71:0] win_grid,
  output logic [71:0] det_grid,
  output logic [7:0]  det_thresh,
  input  logic        det_edge,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_edge,
  output logic [9:0]  out_x,
  output logic [9:0]  out_y,
  output logic        busy,
  output logic        done,
  output logic [15:0] edge_count
);

  localparam logic [9:0] X_LAST = 10'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    CAPT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic [7:0]  thr_q, thr_d;
  logic [71:0] grid_q, grid_d;
  logic        res_q, res_d;
  logic        win_req_q, win_req_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        last_px;

  function automatic logic is_border(input logic [9:0] px, input logic [9:0] py);
    return (px == 10'd0) || (px == X_LAST) || (py == 10'd0) || (py == Y_LAST);
  endfunction

  always_comb begin
    x_next  = (x_q == X_LAST) ? 10'd0 : x_q + 10'd1;
    y_next  = (x_q == X_LAST) ? y_q + 10'd1 : y_q;
    last_px = (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    thr_d       = thr_q;
    grid_d      = grid_q;
    res_d       = res_q;
    win_req_d   = win_req_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          thr_d     = threshold_in;
          x_d       = 10'd0;
          y_d       = 10'd0;
          state_d   = FETCH;
          win_req_d = 1'b0;  // (0,0) is always a border pixel
        end
      end
      FETCH: begin
        if (is_border(x_q, y_q)) begin
          res_d       = 1'b0;
          out_valid_d = 1'b1;
          win_req_d   = 1'b0;
          state_d     = WRITE;
        end else if (win_ack) begin
          grid_d    = win_grid;
          win_req_d = 1'b0;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        state_d = CAPT;
      end
      CAPT: begin
        res_d       = det_edge;
        out_valid_d = 1'b1;
        state_d     = WRITE;
      end
      WRITE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (last_px) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            x_d       = x_next;
            y_d       = y_next;
            win_req_d = !is_border(x_next, y_next);
            state_d   = FETCH;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d     = IDLE;
        win_req_d   = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d     = IDLE;
      win_req_d   = 1'b0;
      out_valid_d = 1'b0;
      done_d      = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= 10'd0;
      y_q         <= 10'd0;
      thr_q       <= 8'd0;
      grid_q      <= 72'd0;
      res_q       <= 1'b0;
      win_req_q   <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      thr_q       <= thr_d;
      grid_q      <= grid_d;
      res_q       <= res_d;
      win_req_q   <= win_req_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

`ifdef EDGE_COUNT_EN
  logic [15:0] edge_count_q, edge_count_d;

  // abort beats a same-cycle handshake, so an aborted result is never counted
  always_comb begin
    edge_count_d = edge_count_q;
    if ((state_q == IDLE) && start) begin
      edge_count_d = 16'd0;
    end else if ((state_q == WRITE) && out_ready && !abort && res_q &&
                 (edge_count_q != 16'hFFFF)) begin
      edge_count_d = edge_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_count_q <= 16'd0;
    end else begin
      edge_count_q <= edge_count_d;
    end
  end

  assign edge_count = edge_count_q;
`else
  assign edge_count = 16'd0;
`endif

  assign win_req    = win_req_q;
  assign win_x      = x_q;
  assign win_y      = y_q;
  assign det_grid   = grid_q;
  assign det_thresh = thr_q;
  assign out_valid  = out_valid_q;
  assign out_edge   = res_q;
  assign out_x      = x_q;
  assign out_y      = y_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_edge_scan_ctrl.sv
// Randomized bench for edge_scan_ctrl on a 4x3 image: a window source, a registered
// edge detector stub and a result sink, checked against a per-pixel expected-result table.
module tb_edge_scan_ctrl;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  threshold_in;
  logic        win_req;
  logic [9:0]  win_x;
  logic [9:0]  win_y;
  logic        win_ack;
  logic [71:0] win_grid;
  logic [71:0] det_grid;
  logic [7:0]  det_thresh;
  logic        det_edge = 1'b0;
  logic        out_valid;
  logic        out_ready;
  logic        out_edge;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic        busy;
  logic        done;
  logic [15:0] edge_count;

  int total = 0;
  int bad   = 0;
  bit det_force_one = 1'b0;

  edge_scan_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .threshold_in(threshold_in),
    .win_req(win_req), .win_x(win_x), .win_y(win_y), .win_ack(win_ack), .win_grid(win_grid),
    .det_grid(det_grid), .det_thresh(det_thresh), .det_edge(det_edge),
    .out_valid(out_valid), .out_ready(out_ready), .out_edge(out_edge),
    .out_x(out_x), .out_y(out_y), .busy(busy), .done(done), .edge_count(edge_count)
  );

  always #5 clk = ~clk;

  // edge when the spread of the nine window bytes exceeds the threshold
  function automatic bit det_fn(input logic [71:0] g, input logic [7:0] t);
    int mx = 0;
    int mn = 255;
    int v;
    for (int i = 0; i < 9; i++) begin
      v = int'(g[i*8 +: 8]);
      if (v > mx) mx = v;
      if (v < mn) mn = v;
    end
    return (mx - mn) > int'(t);
  endfunction

  always @(posedge clk) det_edge <= det_force_one ? 1'b1 : det_fn(det_grid, det_thresh);

  function automatic logic [9:0] px(input int i);
    return 10'(i % W);
  endfunction

  function automatic logic [9:0] py(input int i);
    return 10'(i / W);
  endfunction

  function automatic bit interior(input int i);
    return (i % W > 0) && (i % W < W - 1) && (i / W > 0) && (i / W < H - 1);
  endfunction

  task automatic check_eq(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input int exp_cnt);
`ifdef EDGE_COUNT_EN
    check_eq("edge_count", 72'(edge_count), 72'(exp_cnt));
`else
    check_eq("edge_count", 72'(edge_count), 72'(exp_cnt * 0));
`endif
  endtask

  // stop_kind: 0 run to done, 1 abort in EVAL of stop_idx, 2 reset while fetching stop_idx
  task automatic run_scan(input logic [7:0] thr, input int dmin, input int dmax,
                          input int ready_pct, input int hold_min, input bit chg_thr,
                          input int stop_kind, input int stop_idx);
    logic [71:0] grids [N];
    bit          exp_e [N];
    int          res_idx, since_ack, wait_cnt, cur_delay, vcyc, exp_cnt;
    bit          hold, req_pending, got_ack, done_now, done_next, finished, stopped, r;

    for (int i = 0; i < N; i++) begin
      grids[i] = {8'($urandom), $urandom, $urandom};
      exp_e[i] = interior(i) && (det_force_one || det_fn(grids[i], thr));
    end

    @(negedge clk);
    threshold_in = thr;
    start        = 1'b1;
    abort        = 1'($urandom_range(0, 1));
    win_ack      = 1'b0;
    out_ready    = 1'($urandom_range(0, 1));
    exp_cnt = 0; res_idx = 0; since_ack = -1; wait_cnt = 0; vcyc = 0;
    cur_delay = $urandom_range(dmin, dmax);
    hold = 0; req_pending = 0; got_ack = 0; done_next = 0; finished = 0; stopped = 0;

    for (int cyc = 0; cyc < 3000 && !finished && !stopped; cyc++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 7) == 0);
      abort    = 1'b0;
      if (chg_thr && cyc == 15) threshold_in = 8'h80;
      done_now  = done_next;
      done_next = 0;

      check_eq("busy", 72'(busy), 72'(1));
      check_eq("done", 72'(done), 72'(done_now));
      check_eq("det_thresh", 72'(det_thresh), 72'(thr));
      check_eq("req_with_valid", 72'(win_req & out_valid), 72'(0));
      check_count(exp_cnt);
      if (done_now) finished = 1;
      if (hold) check_eq("valid_held", 72'(out_valid), 72'(1));
      if (req_pending && since_ack < 0) check_eq("req_held", 72'(win_req), 72'(1));

      if (since_ack >= 0) begin
        since_ack++;
        if (since_ack <= 2) begin
          check_eq("det_grid", det_grid, grids[res_idx]);
          check_eq("lat_valid_lo", 72'(out_valid), 72'(0));
        end
        if (since_ack == 1) check_eq("req_drop", 72'(win_req), 72'(0));
        if (since_ack == 3) begin
          check_eq("lat_valid_hi", 72'(out_valid), 72'(1));
          since_ack = -1;
        end
      end

      if (win_req) begin
        check_eq("req_in_range", 72'(res_idx < N), 72'(1));
        if (res_idx < N) begin
          check_eq("win_x", 72'(win_x), 72'(px(res_idx)));
          check_eq("win_y", 72'(win_y), 72'(py(res_idx)));
          check_eq("req_interior", 72'(interior(res_idx)), 72'(1));
        end
      end

      if (stop_kind == 1 && since_ack == 1 && res_idx == stop_idx) begin
        abort   = 1'b1;
        stopped = 1;
        continue;
      end
      if (stop_kind == 2 && win_req && since_ack < 0 && res_idx == stop_idx) begin
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check_eq("rst_win_req", 72'(win_req), 72'(0));
        check_eq("rst_busy", 72'(busy), 72'(0));
        check_eq("rst_out_valid", 72'(out_valid), 72'(0));
        check_eq("rst_det_thresh", 72'(det_thresh), 72'(0));
        check_eq("rst_det_grid", det_grid, 72'(0));
        check_eq("rst_edge_count", 72'(edge_count), 72'(0));
        stopped = 1;
        continue;
      end

      if (win_req && since_ack < 0) begin
        req_pending = 1;
        if (wait_cnt >= cur_delay && res_idx < N) begin
          win_ack     = 1'b1;
          win_grid    = grids[res_idx];
          since_ack   = 0;
          wait_cnt    = 0;
          cur_delay   = $urandom_range(dmin, dmax);
          req_pending = 0;
          got_ack     = 1;
        end else begin
          win_ack  = 1'b0;
          win_grid = {8'($urandom), $urandom, $urandom};
          wait_cnt++;
        end
      end else begin
        win_ack  = ($urandom_range(0, 3) == 0);
        win_grid = {8'($urandom), $urandom, $urandom};
      end

      if (out_valid) vcyc++;
      r = (out_valid && vcyc <= hold_min) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
      out_ready = r;
      hold = 0;
      if (out_valid) begin
        check_eq("out_in_range", 72'(res_idx < N), 72'(1));
        if (res_idx < N) begin
          check_eq("out_x", 72'(out_x), 72'(px(res_idx)));
          check_eq("out_y", 72'(out_y), 72'(py(res_idx)));
          check_eq("out_edge", 72'(out_edge), 72'(exp_e[res_idx]));
          check_eq("fetched_first", 72'(!interior(res_idx) || got_ack), 72'(1));
          if (r) begin
            if (exp_e[res_idx]) exp_cnt++;
            res_idx++;
            vcyc    = 0;
            got_ack = 0;
            if (res_idx == N) done_next = 1;
          end else begin
            hold = 1;
          end
        end
      end
    end

    if (stop_kind == 0) begin
      check_eq("scan_finished", 72'(finished), 72'(1));
      @(negedge clk);
      start = 1'b0; abort = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
      check_eq("end_busy", 72'(busy), 72'(0));
      check_eq("end_done", 72'(done), 72'(0));
      check_eq("end_valid", 72'(out_valid), 72'(0));
      check_eq("end_req", 72'(win_req), 72'(0));
      check_count(exp_cnt);
    end else if (stop_kind == 1) begin
      check_eq("abort_reached", 72'(stopped), 72'(1));
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        start = 1'b0; abort = 1'b0; win_ack = 1'b0; out_ready = 1'b0;
        check_eq("abort_busy", 72'(busy), 72'(0));
        check_eq("abort_valid", 72'(out_valid), 72'(0));
        check_eq("abort_done", 72'(done), 72'(0));
        check_eq("abort_req", 72'(win_req), 72'(0));
        check_count(exp_cnt);
      end
    end else begin
      check_eq("reset_reached", 72'(stopped), 72'(1));
      win_ack = 1'b0; out_ready = 1'b0; abort = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        check_eq("post_rst_busy", 72'(busy), 72'(0));
        check_eq("post_rst_req", 72'(win_req), 72'(0));
        check_eq("post_rst_done", 72'(done), 72'(0));
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; threshold_in = 8'h00;
    win_ack = 1'b0; win_grid = 72'd0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_busy", 72'(busy), 72'(0));
    check_eq("reset_done", 72'(done), 72'(0));
    check_eq("reset_req", 72'(win_req), 72'(0));
    check_eq("reset_valid", 72'(out_valid), 72'(0));
    check_eq("reset_count", 72'(edge_count), 72'(0));
    check_eq("reset_grid", det_grid, 72'(0));
    check_eq("reset_thresh", 72'(det_thresh), 72'(0));
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_busy", 72'(busy), 72'(0));

    det_force_one = 1'b1;
    run_scan(8'h10, 0, 0, 100, 0, 1'b0, 0, 0);
    det_force_one = 1'b0;
    run_scan(8'h30, 5, 5, 100, 0, 1'b0, 0, 0);
    run_scan(8'h30, 0, 2, 100, 4, 1'b0, 0, 0);
    run_scan(8'h20, 0, 3, 70, 0, 1'b1, 0, 0);
    run_scan(8'h80, 0, 2, 80, 0, 1'b0, 0, 0);
    run_scan(8'h40, 0, 2, 80, 0, 1'b0, 1, 6);
    run_scan(8'h40, 0, 3, 80, 0, 1'b0, 2, 5);
    for (int k = 0; k < 8; k++) begin
      run_scan(8'($urandom_range(0, 255)), 0, $urandom_range(0, 4),
               $urandom_range(30, 100), $urandom_range(0, 2), 1'b0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
